// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore sequencing FSM plus ALU decoder.
// Drives every datapath mux select and write enable from op, funct and zero.
//
// state   | meaning
// FETCH   | read instruction at PC into IR, PC <= PC + 4
// DECODE  | read registers, precompute branch target into ALUOut
// MEMADR  | compute load/store address
// MEMRD   | read data memory at ALUOut
// MEMWB   | write loaded data to rt
// MEMWR   | write B to data memory at ALUOut
// EXECUTE | R-type ALU operation
// ALUWB   | write ALUOut to rd
// BEQ     | compare, take branch when zero
// ADDIEX  | add sign-extended immediate
// ADDIWB  | write ALUOut to rt
// JUMP    | load jump target into PC
// BNE     | compare, take branch when not zero
module mc_controller #(
  parameter bit SUPPORT_BNE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       iord,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQ     = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_BNE     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     cur_state;
  state_t     nxt_state;

  logic       pcwrite;
  logic       branch;
  logic       branch_ne;
  logic       irwrite_c;
  logic       regwrite_c;
  logic       memwrite_c;
  logic [1:0] aluop;
  logic       op_bad;
  logic       ctl_valid;
  logic [2:0] alu_dec;
  logic       funct_bad;
  logic       branch_taken;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur_state <= S_FETCH;
    else        cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state  = S_FETCH;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    branch_ne  = 1'b0;
    irwrite_c  = 1'b0;
    regwrite_c = 1'b0;
    memwrite_c = 1'b0;
    iord       = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = 2'b00;
    op_bad     = 1'b0;
    ctl_valid  = 1'b1;
    case (cur_state)
      S_FETCH: begin
        alusrcb   = 2'b01;
        irwrite_c = 1'b1;
        pcwrite   = 1'b1;
        nxt_state = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: nxt_state = S_MEMADR;
          OP_RTYPE:     nxt_state = S_EXECUTE;
          OP_BEQ:       nxt_state = S_BEQ;
          OP_ADDI:      nxt_state = S_ADDIEX;
          OP_J:         nxt_state = S_JUMP;
          OP_BNE: begin
            if (SUPPORT_BNE) nxt_state = S_BNE;
            else             op_bad    = 1'b1;
          end
          default:      op_bad = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        // op is held in IR; anything but lw/sw here cannot occur, so fall back to FETCH
        if (op == OP_LW)      nxt_state = S_MEMRD;
        else if (op == OP_SW) nxt_state = S_MEMWR;
      end
      S_MEMRD: begin
        iord      = 1'b1;
        nxt_state = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_c = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite_c = 1'b1;
      end
      S_EXECUTE: begin
        alusrca   = 1'b1;
        aluop     = 2'b10;
        nxt_state = S_ALUWB;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        regwrite_c = 1'b1;
      end
      S_BEQ: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      S_BNE: begin
        alusrca   = 1'b1;
        aluop     = 2'b01;
        pcsrc     = 2'b01;
        branch    = 1'b1;
        branch_ne = 1'b1;
      end
      S_ADDIEX: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        nxt_state = S_ADDIWB;
      end
      S_ADDIWB: regwrite_c = 1'b1;
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ctl_valid = 1'b0;
    endcase
  end

  always_comb begin
    alu_dec   = 3'b010;
    funct_bad = 1'b0;
    case (aluop)
      2'b00: alu_dec = 3'b010;
      2'b01: alu_dec = 3'b110;
      default: begin
        case (funct)
          6'b100000: alu_dec = 3'b010;
          6'b100010: alu_dec = 3'b110;
          6'b100100: alu_dec = 3'b000;
          6'b100101: alu_dec = 3'b001;
          6'b101010: alu_dec = 3'b111;
          default: begin
            alu_dec   = 3'b010;
            funct_bad = 1'b1;
          end
        endcase
      end
    endcase
  end

  assign branch_taken = branch & (branch_ne ? ~zero : zero);

  // Write enables and illegal are gated by reset so an aborted instruction commits nothing.
  assign pcen       = reset & (pcwrite | branch_taken);
  assign irwrite    = reset & irwrite_c;
  assign regwrite   = reset & regwrite_c;
  assign memwrite   = reset & memwrite_c;
  assign illegal    = reset & (op_bad | ((cur_state == S_EXECUTE) & funct_bad));
  assign alucontrol = ctl_valid ? alu_dec : 3'b000;
  assign state      = cur_state;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class state by state
// and compares the full output vector against hand-computed values.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;

  logic       pcen, irwrite, regwrite, memwrite, iord, regdst, memtoreg, alusrca, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  logic       n_pcen, n_irwrite, n_regwrite, n_memwrite, n_iord, n_regdst, n_memtoreg;
  logic       n_alusrca, n_illegal;
  logic [1:0] n_alusrcb, n_pcsrc;
  logic [2:0] n_alucontrol;
  logic [3:0] n_state;

  int vectors = 0;
  int miscompares = 0;

  mc_controller #(.SUPPORT_BNE(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite), .memwrite(memwrite),
    .iord(iord), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
    .illegal(illegal), .state(state)
  );

  mc_controller #(.SUPPORT_BNE(1'b0)) dut_nobne (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(n_pcen), .irwrite(n_irwrite), .regwrite(n_regwrite), .memwrite(n_memwrite),
    .iord(n_iord), .regdst(n_regdst), .memtoreg(n_memtoreg), .alusrca(n_alusrca),
    .alusrcb(n_alusrcb), .pcsrc(n_pcsrc), .alucontrol(n_alucontrol),
    .illegal(n_illegal), .state(n_state)
  );

  always #5 clk = ~clk;

  // {pcen,irwrite,regwrite,memwrite,iord,regdst,memtoreg,alusrca,alusrcb,pcsrc,alucontrol,illegal,state}
  logic [19:0] obs, obs_n;
  assign obs   = {pcen, irwrite, regwrite, memwrite, iord, regdst, memtoreg, alusrca,
                  alusrcb, pcsrc, alucontrol, illegal, state};
  assign obs_n = {n_pcen, n_irwrite, n_regwrite, n_memwrite, n_iord, n_regdst, n_memtoreg,
                  n_alusrca, n_alusrcb, n_pcsrc, n_alucontrol, n_illegal, n_state};

  function automatic logic [19:0] v(input bit pe, input bit irw, input bit rw, input bit mw,
                                    input bit io, input bit rd, input bit m2r, input bit asa,
                                    input logic [1:0] asb, input logic [1:0] psrc,
                                    input logic [2:0] alc, input bit ill, input logic [3:0] st);
    return {pe, irw, rw, mw, io, rd, m2r, asa, asb, psrc, alc, ill, st};
  endfunction

  task automatic chk(input string tag, input logic [19:0] exp);
    #1;
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_n(input string tag, input logic [19:0] exp);
    #1;
    vectors++;
    assert (obs_n === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs_n, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [19:0] f_v, d_v, rst_v;
  logic [5:0]  fn_tab  [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b111111};
  logic [2:0]  alc_tab [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b010};
  bit          ill_tab [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    f_v   = v(1,1,0,0,0,0,0,0,2'b01,2'b00,3'b010,0,4'd0);
    d_v   = v(0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0,4'd1);
    rst_v = v(0,0,0,0,0,0,0,0,2'b01,2'b00,3'b010,0,4'd0);

    reset = 1'b0; op = 6'b100011; funct = 6'b000000; zero = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset", rst_v);
    chk_n("reset_nobne", rst_v);

    // lw: 0,1,2,3,4,0
    @(negedge clk);
    reset = 1'b1;
    chk("lw_fetch", f_v);
    tick(); chk("lw_decode", d_v);
    tick(); chk("lw_memadr", v(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0,4'd2));
    tick(); chk("lw_memrd",  v(0,0,0,0,1,0,0,0,2'b00,2'b00,3'b010,0,4'd3));
    tick(); chk("lw_memwb",  v(0,0,1,0,0,0,1,0,2'b00,2'b00,3'b010,0,4'd4));
    tick();
    // sw: 0,1,2,5,0
    op = 6'b101011;
    chk("sw_fetch", f_v);
    tick(); chk("sw_decode", d_v);
    tick(); chk("sw_memadr", v(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0,4'd2));
    tick(); chk("sw_memwr",  v(0,0,0,1,1,0,0,0,2'b00,2'b00,3'b010,0,4'd5));
    tick();
    // R-type slt
    op = 6'b000000; funct = 6'b101010;
    chk("slt_fetch", f_v);
    tick(); chk("slt_decode", d_v);
    tick(); chk("slt_exec",  v(0,0,0,0,0,0,0,1,2'b00,2'b00,3'b111,0,4'd6));
    tick(); chk("slt_aluwb", v(0,0,1,0,0,1,0,0,2'b00,2'b00,3'b010,0,4'd7));
    tick();
    // remaining functs, last one unsupported
    for (int i = 0; i < 5; i++) begin
      funct = fn_tab[i];
      tick();
      tick(); chk($sformatf("rtype_exec_%0d", i),
                  v(0,0,0,0,0,0,0,1,2'b00,2'b00,alc_tab[i],ill_tab[i],4'd6));
      tick(); chk($sformatf("rtype_aluwb_%0d", i),
                  v(0,0,1,0,0,1,0,0,2'b00,2'b00,3'b010,0,4'd7));
      tick();
    end
    // addi
    op = 6'b001000;
    chk("addi_fetch", f_v);
    tick();
    tick(); chk("addi_ex", v(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0,4'd9));
    tick(); chk("addi_wb", v(0,0,1,0,0,0,0,0,2'b00,2'b00,3'b010,0,4'd10));
    tick();
    // j
    op = 6'b000010;
    tick();
    tick(); chk("jump", v(1,0,0,0,0,0,0,0,2'b00,2'b10,3'b010,0,4'd11));
    tick(); chk("jump_next", f_v);
    // beq taken and not taken
    op = 6'b000100; zero = 1'b1;
    tick();
    tick(); chk("beq_taken", v(1,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,0,4'd8));
    zero = 1'b0;
    tick();
    tick();
    tick(); chk("beq_not_taken", v(0,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,0,4'd8));
    tick();
    // unsupported opcode
    op = 6'b111111;
    tick(); chk("illop_decode", v(0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,1,4'd1));
    tick(); chk("illop_next", f_v);
    // bne on both builds; the bne-less build treats it as illegal
    op = 6'b000101; zero = 1'b0;
    chk_n("nobne_fetch", f_v);
    tick(); chk("bne_decode", d_v);
    chk_n("nobne_decode", v(0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,1,4'd1));
    tick(); chk("bne_taken", v(1,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,0,4'd12));
    chk_n("nobne_next", f_v);
    zero = 1'b1;
    tick();
    tick();
    tick(); chk("bne_not_taken", v(0,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,0,4'd12));
    tick();
    // lw aborted by reset while in MEMRD
    op = 6'b100011; zero = 1'b0;
    tick();
    tick();
    tick(); chk("abort_memrd", v(0,0,0,0,1,0,0,0,2'b00,2'b00,3'b010,0,4'd3));
    reset = 1'b0;
    chk("abort_async", rst_v);
    chk_n("abort_async_nobne", rst_v);
    tick(); chk("abort_held", rst_v);
    reset = 1'b1;
    chk("abort_release", f_v);
    tick(); chk("abort_decode", d_v);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Control unit for the multicycle MIPS datapath, the follow-on to the single-cycle core.
- Sequences instruction fetch, decode, execute, memory and writeback over several clock cycles so one memory and one ALU are shared across phases.
- Moore FSM plus an ALU decoder; it drives every mux select and write enable of the datapath from op, funct and the ALU zero flag.

Parameters:
SUPPORT_BNE, 1, when 1 opcode 000101 (bne) is executed; when 0 it is treated as illegal.

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
op  input  6  instr[31:26] from the instruction register
funct  input  6  instr[5:0] from the instruction register
zero  input  1  ALU zero flag, same cycle
pcen  output  1  PC register enable = pcwrite | (branch & branch condition)
irwrite  output  1  instruction register write enable
regwrite  output  1  register file write enable
memwrite  output  1  data/instruction memory write enable
iord  output  1  memory address select: 0 = PC, 1 = ALUOut
regdst  output  1  write register: 0 = rt, 1 = rd
memtoreg  output  1  writeback data: 0 = ALUOut, 1 = Data register
alusrca  output  1  ALU A: 0 = PC, 1 = A register
alusrcb  output  2  ALU B: 00 = B register, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2
pcsrc  output  2  next PC: 00 = ALUResult, 01 = ALUOut, 10 = jump target
alucontrol  output  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt
illegal  output  1  one-cycle pulse on an unsupported opcode or funct
state  output  4  current FSM state, for debug

Behaviour:
- State register is 4 bits.
  - Asynchronous reset: state = FETCH(0) immediately when reset = 0.
  - Otherwise the state updates on the rising edge of clk.
- While reset = 0:
  - pcen, irwrite, regwrite and memwrite are forced to 0.
  - illegal is forced to 0.
  - All other outputs take their FETCH values.
- States: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BEQ 8, ADDIEX 9, ADDIWB 10, JUMP 11, BNE 12. Codes 13-15 go to FETCH on the next edge, with all outputs 0.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: op 100011 (lw) or 101011 (sw) -> MEMADR; 000000 -> EXECUTE; 000100 -> BEQ; 001000 -> ADDIEX; 000010 -> JUMP; 000101 -> BNE if SUPPORT_BNE; any other op -> FETCH with illegal = 1 during DECODE.
  - MEMADR: lw -> MEMRD, sw -> MEMWR.
  - MEMRD -> MEMWB -> FETCH.
  - MEMWR -> FETCH.
  - EXECUTE -> ALUWB -> FETCH.
  - ADDIEX -> ADDIWB -> FETCH.
  - BEQ, BNE, JUMP -> FETCH.
- Outputs are a function of state only (Moore), except pcen, which also depends on zero, and alucontrol, which also depends on funct. Any signal not listed for a state is 0.
  - FETCH: alusrcb 01, irwrite 1, pcwrite 1.
  - DECODE: alusrcb 11.
  - MEMADR: alusrca 1, alusrcb 10.
  - MEMRD: iord 1.
  - MEMWB: memtoreg 1, regwrite 1.
  - MEMWR: iord 1, memwrite 1.
  - EXECUTE: alusrca 1, aluop 10.
  - ALUWB: regdst 1, regwrite 1.
  - BEQ: alusrca 1, aluop 01, pcsrc 01; pcen = zero.
  - BNE: as BEQ, but pcen = ~zero.
  - ADDIEX: alusrca 1, alusrcb 10.
  - ADDIWB: regwrite 1.
  - JUMP: pcsrc 10, pcwrite 1.
- ALU decoder (combinational):
  - aluop 00 -> 010; aluop 01 -> 110.
  - aluop 10 decodes funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
  - Any other funct -> 010, with illegal = 1 during EXECUTE only; the sequence still proceeds to ALUWB.
- Instruction latency, counting FETCH as cycle 1: lw 5, sw 4, R-type 4, addi 4, beq 3, bne 3, j 3.
- Reset asserted mid-instruction: the instruction is aborted with no further write enables. After reset releases, the first rising edge evaluates FETCH.

Test Plan:
- Reset low for 2 cycles, then release -> state 0 and all write enables 0 during reset; on the first FETCH cycle irwrite = 1, pcen = 1, alusrcb = 01.
- lw (op 100011) -> states 0,1,2,3,4,0; memtoreg = 1 and regwrite = 1 only in state 4; iord = 1 in state 3; memwrite never 1.
- sw (op 101011) -> states 0,1,2,5,0; memwrite = 1 and iord = 1 for exactly one cycle in state 5.
- R-type slt (op 000000, funct 101010) -> alucontrol = 111 and aluop = 10 in state 6; regdst = 1, regwrite = 1 in state 7. Repeating with funct 111111 gives alucontrol = 010 and a one-cycle illegal pulse in state 6.
- beq with zero = 1 -> pcen = 1 in state 8; with zero = 0 -> pcen = 0. bne with zero = 0 -> pcen = 1 in state 12. Rebuild with SUPPORT_BNE = 0 and apply op 000101 -> illegal = 1 in state 1, next state 0.
- Reset driven low while in state 3 of a lw -> state 0 asynchronously before the next edge; regwrite never asserts for that lw.
